fetch_stage: RTL



---
 rtl/fetch_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional ADDR_FAULT_EN macro enables redirect-target legality checking and a sticky AddrFault flag.
module fetch_stage #(
    parameter int unsigned                DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]      TEXT_BASE    = 32'h0040_0000,
    parameter int unsigned                MEMORY_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  Jump,
    input  logic [DATA_WIDTH-1:0] JumpTarget,
    input  logic [DATA_WIDTH-1:0] InstructionIn,
    output logic [DATA_WIDTH-1:0] PC_out,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  AddrFault
);

    localparam logic [DATA_WIDTH-1:0] WORD_STEP = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] LAST_PC   = TEXT_BASE + DATA_WIDTH'(4 * (MEMORY_DEPTH - 1));

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] seq_pc;
    logic [DATA_WIDTH-1:0] target_raw;
    logic [DATA_WIDTH-1:0] target;
    logic                  redirect;
    logic                  target_ok;

    assign pc_plus4 = pc_q + WORD_STEP;
    assign seq_pc   = (pc_q == LAST_PC) ? TEXT_BASE : pc_plus4;
    assign redirect = Jump | BranchTaken;

`ifdef ADDR_FAULT_EN
    localparam logic [DATA_WIDTH-1:0] TEXT_END = TEXT_BASE + DATA_WIDTH'(4 * MEMORY_DEPTH - 1);

    always_comb begin
        target_raw = Jump ? JumpTarget : BranchTarget;
        target     = target_raw;
        target_ok  = (target_raw[1:0] == 2'b00) &&
                     (target_raw >= TEXT_BASE) && (target_raw <= TEXT_END);
    end

    logic fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (redirect && !target_ok) begin
            fault_q <= 1'b1;
        end
    end

    assign AddrFault = fault_q;
`else
    // Without fault checking every target is accepted with its byte offset dropped.
    always_comb begin
        target_raw = Jump ? JumpTarget : BranchTarget;
        target     = target_raw & ~DATA_WIDTH'(3);
        target_ok  = 1'b1;
    end

    assign AddrFault = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            if (target_ok) begin
                pc_d = target;
            end
        end else if (!Stall) begin
            pc_d = seq_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= TEXT_BASE;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A redirect (legal or not) always kills the wrong-path word being fetched this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IFID_Instruction <= '0;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else if (Flush || redirect) begin
            IFID_Instruction <= '0;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else if (!Stall) begin
            IFID_Instruction <= InstructionIn;
            IFID_PCPlus4     <= pc_plus4;
            IFID_Valid       <= 1'b1;
        end
    end

    assign PC_out = pc_q;

endmodule
